// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing/pattern generator: mode encoding,
// colour-bar table, default 640x480@60 timing and the counter bundle type.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  // {r,g,b} on/off flags, index 0 = leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Raw timing state of the current counter position (pre-output-register).
  typedef struct packed {
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             hs;
    logic             vs;
    logic             de;
    logic             fstart;
    logic             line_end;
  } tstate_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters plus sync, data-enable and frame-start decode.
// Sync flags here are active-high; polarity is applied at the output register.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic    clk_pix,
  input  logic    reset,
  output tstate_t ts_o
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit 10-bit counters");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + CNT_W'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  always_comb begin
    ts_o.hc       = hc_q;
    ts_o.vc       = vc_q;
    ts_o.hs       = (hc_q >= HS_START) && (hc_q <= HS_END);
    ts_o.vs       = (vc_q >= VS_START) && (vc_q <= VS_END);
    ts_o.de       = (hc_q < H_ACT) && (vc_q < V_ACT);
    ts_o.fstart   = (hc_q == '0) && (vc_q == '0);
    ts_o.line_end = (hc_q == H_LAST);
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: frame-latched mode select, solid/bars/checker/
// bouncing-box patterns and a single output register stage.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W    = 3,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32
) (
  input  logic                 clk_pix,
  input  logic                 reset,
  input  logic [1:0]           mode_in,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [CNT_W-1:0]     hcount,
  output logic [CNT_W-1:0]     vcount,
  output logic                 de,
  output logic                 hsync,
  output logic                 vsync,
  output logic [COLOR_W-1:0]   rgb_r,
  output logic [COLOR_W-1:0]   rgb_g,
  output logic [COLOR_W-1:0]   rgb_b,
  output logic                 frame_start,
  output logic [1:0]           mode_active
);

  if (BOX_SIZE >= H_ACTIVE || BOX_SIZE >= V_ACTIVE || H_ACTIVE < 8) begin : g_bad_geom
    $error("vga_pattern_gen: BOX_SIZE must be below H_ACTIVE/V_ACTIVE and H_ACTIVE >= 8");
  end

  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [CNT_W-1:0] BOX_XMAX = CNT_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [CNT_W-1:0] BOX_YMAX = CNT_W'(V_ACTIVE - BOX_SIZE);

  tstate_t ts;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_pix (clk_pix),
    .reset   (reset),
    .ts_o    (ts)
  );

  // Returns {fwd_next, pos_next}; fwd = 1 means moving toward lim.
  function automatic logic [CNT_W:0] bounce(input logic [CNT_W-1:0] pos, input logic fwd,
                                            input logic [CNT_W-1:0] lim);
    if (fwd && pos == lim)      return {1'b0, pos - CNT_W'(1)};
    else if (!fwd && pos == '0) return {1'b1, CNT_W'(1)};
    else if (fwd)               return {1'b1, pos + CNT_W'(1)};
    else                        return {1'b0, pos - CNT_W'(1)};
  endfunction

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] bx_q, bx_d, by_q, by_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic [CNT_W-1:0] bar_px_q, bar_px_d;
  logic [2:0]       bar_idx_q, bar_idx_d;

  // Frame-boundary state is applied combinationally so pixel (0,0) already
  // renders with the newly latched mode and box position.
  always_comb begin
    mode_d = mode_q;
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (ts.fstart) begin
      mode_d     = mode_e'(mode_in);
      {dx_d, bx_d} = bounce(bx_q, dx_q, BOX_XMAX);
      {dy_d, by_d} = bounce(by_q, dy_q, BOX_YMAX);
    end
  end

  // Bar index tracks the current hc; last bar absorbs the H_ACTIVE%8 remainder.
  always_comb begin
    bar_px_d  = bar_px_q + CNT_W'(1);
    bar_idx_d = bar_idx_q;
    if (ts.line_end) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d = '0;
      if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
    end
  end

  logic             in_box;
  logic [2:0]       flags;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    in_box = ({1'b0, ts.hc} >= {1'b0, bx_d}) &&
             ({1'b0, ts.hc} <  {1'b0, bx_d} + (CNT_W+1)'(BOX_SIZE)) &&
             ({1'b0, ts.vc} >= {1'b0, by_d}) &&
             ({1'b0, ts.vc} <  {1'b0, by_d} + (CNT_W+1)'(BOX_SIZE));
    flags = '0;
    case (mode_d)
      MODE_BARS:  flags = BAR_TABLE[bar_idx_q];
      MODE_CHECK: flags = {3{ts.hc[CHECK_LOG2] ^ ts.vc[CHECK_LOG2]}};
      MODE_BOX:   flags = {3{in_box}};
      default:    flags = '0;
    endcase
    if (mode_d == MODE_SOLID) begin
      pix_r = solid_rgb[3*COLOR_W-1 -: COLOR_W];
      pix_g = solid_rgb[2*COLOR_W-1 -: COLOR_W];
      pix_b = solid_rgb[COLOR_W-1:0];
    end else begin
      pix_r = {COLOR_W{flags[2]}};
      pix_g = {COLOR_W{flags[1]}};
      pix_b = {COLOR_W{flags[0]}};
    end
    if (!ts.de) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      mode_q    <= MODE_SOLID;
      bx_q      <= '0;
      by_q      <= '0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else begin
      mode_q    <= mode_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      rgb_r       <= '0;
      rgb_g       <= '0;
      rgb_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= ts.hc;
      vcount      <= ts.vc;
      de          <= ts.de;
      hsync       <= ts.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= ts.vs ? SYNC_POL : ~SYNC_POL;
      rgb_r       <= pix_r;
      rgb_g       <= pix_g;
      rgb_b       <= pix_b;
      frame_start <= ts.fstart;
    end
  end

  assign mode_active = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Random-stimulus bench for vga_pattern_gen on a shrunken raster, compared
// cycle by cycle against an arithmetic model of the output pixel stream.
module tb_vga_pattern_gen;

  localparam int CW = 3;
  localparam int HA = 42, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 12, VFP = 1, VS = 2, VBP = 1;
  localparam int CL = 2;
  localparam int BOX = 8;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int BAR_W = HA / 8;
  localparam int ON = (1 << CW) - 1;

  logic          clk_pix = 1'b0;
  logic          reset;
  logic [1:0]    mode_in;
  logic [3*CW-1:0] solid_rgb;
  logic [9:0]    hcount, vcount;
  logic          de, hsync, vsync, frame_start;
  logic [CW-1:0] rgb_r, rgb_g, rgb_b;
  logic [1:0]    mode_active;

  always #5 clk_pix = ~clk_pix;

  vga_pattern_gen #(
    .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .CHECK_LOG2(CL), .BOX_SIZE(BOX)
  ) dut (
    .clk_pix     (clk_pix),
    .reset       (reset),
    .mode_in     (mode_in),
    .solid_rgb   (solid_rgb),
    .hcount      (hcount),
    .vcount      (vcount),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb_r       (rgb_r),
    .rgb_g       (rgb_g),
    .rgb_b       (rgb_b),
    .frame_start (frame_start),
    .mode_active (mode_active)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // colour bars as {r,g,b} on-flags, left to right
  int bar_rgb[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  int p = -1;      // pixel index since reset release; -1 while in reset
  int m_mode = 0;
  int e_h, e_v, e_de, e_hs, e_vs, e_r, e_g, e_b, e_fs, e_mode;

  // box position in frame f (f=1 is the first frame after reset): triangle wave
  function automatic int tri_pos(input int f, input int r);
    int m;
    m = f % (2 * r);
    return (m <= r) ? m : 2 * r - m;
  endfunction

  task automatic predict();
    int x, y, f, fl, bx, by;
    if (reset) begin
      p = -1; m_mode = 0;
      e_h = 0; e_v = 0; e_de = 0; e_hs = 1; e_vs = 1;
      e_r = 0; e_g = 0; e_b = 0; e_fs = 0; e_mode = 0;
      return;
    end
    p++;
    x = p % HT;
    y = (p / HT) % VT;
    f = p / FRAME + 1;
    if (x == 0 && y == 0) m_mode = int'(mode_in);
    e_h = x; e_v = y;
    e_de = (x < HA && y < VA) ? 1 : 0;
    e_hs = (x >= HA + HFP && x < HA + HFP + HS) ? 0 : 1;
    e_vs = (y >= VA + VFP && y < VA + VFP + VS) ? 0 : 1;
    e_fs = (x == 0 && y == 0) ? 1 : 0;
    e_mode = m_mode;
    fl = 0;
    case (m_mode)
      1: fl = bar_rgb[(x / BAR_W > 7) ? 7 : x / BAR_W];
      2: fl = (((x >> CL) ^ (y >> CL)) & 1) ? 7 : 0;
      3: begin
        bx = tri_pos(f, HA - BOX);
        by = tri_pos(f, VA - BOX);
        fl = (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 7 : 0;
      end
      default: fl = 0;
    endcase
    if (m_mode == 0) begin
      e_r = int'(solid_rgb[3*CW-1 -: CW]);
      e_g = int'(solid_rgb[2*CW-1 -: CW]);
      e_b = int'(solid_rgb[CW-1:0]);
    end else begin
      e_r = fl[2] ? ON : 0;
      e_g = fl[1] ? ON : 0;
      e_b = fl[0] ? ON : 0;
    end
    if (e_de == 0) begin
      e_r = 0; e_g = 0; e_b = 0;
    end
  endtask

  task automatic compare();
    chk("hcount", int'(hcount), e_h);
    chk("vcount", int'(vcount), e_v);
    chk("de", int'(de), e_de);
    chk("hsync", int'(hsync), e_hs);
    chk("vsync", int'(vsync), e_vs);
    chk("frame_start", int'(frame_start), e_fs);
    chk("mode_active", int'(mode_active), e_mode);
    chk("rgb_r", int'(rgb_r), e_r);
    chk("rgb_g", int'(rgb_g), e_g);
    chk("rgb_b", int'(rgb_b), e_b);
  endtask

  // one clock: choose inputs, predict the resulting output pixel, then check it
  task automatic cycle(input bit rst);
    int nf;
    reset = rst;
    nf = (p + 1) / FRAME + 1;
    if (nf >= HA - BOX - 1 && nf <= HA - BOX + 3) mode_in = 2'd3;  // cover the right-edge bounce
    else if ($urandom_range(0, 199) == 0) mode_in = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 49) == 0) solid_rgb = (3*CW)'($urandom);
    predict();
    @(posedge clk_pix);
    #1;
    compare();
  endtask

  initial begin
    reset = 1'b1;
    mode_in = 2'd0;
    solid_rgb = 9'b101_010_111;
    repeat (5) cycle(1'b1);
    repeat ($urandom_range(2000, 3000)) cycle(1'b0);
    cycle(1'b1);  // mid-frame reset pulse
    repeat (40 * FRAME) cycle(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator, and the next generation of the team's fixed 640x480 white/black VGA top. Timing is fully parametrised (active, porches, sync widths, sync polarity) and colour depth is configurable. It offers four selectable pattern modes, including an animated bouncing box. It sits directly behind the pixel clock and drives the board DAC pins, and it is also used as the bring-up source for later framebuffer work.

Parameters:
COLOR_W, 3, bits per colour component
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CHECK_LOG2, 5, checkerboard square edge = 2**CHECK_LOG2 pixels
BOX_SIZE, 32, bouncing-box edge in pixels (must be less than H_ACTIVE and V_ACTIVE)

Ports:
clk_pix  in  1  pixel clock
reset  in  1  synchronous active-high reset
mode_in  in  2  requested pattern: 0 solid, 1 colour bars, 2 checkerboard, 3 bouncing box
solid_rgb  in  3*COLOR_W  colour for mode 0, packed {r,g,b}
hcount  out  10  horizontal position of the current output pixel
vcount  out  10  vertical position of the current output pixel
de  out  1  data enable (inside the active area)
hsync  out  1  horizontal sync at SYNC_POL level
vsync  out  1  vertical sync at SYNC_POL level
rgb_r / rgb_g / rgb_b  out  COLOR_W each  pixel colour (0 when de=0)
frame_start  out  1  one-cycle pulse that coincides with output pixel (0,0)
mode_active  out  2  mode currently being displayed

Behaviour:
- One clock (clk_pix); reset is synchronous and active-high. All state updates on the rising edge of clk_pix.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (defaults: 800 and 525).
- Counters:
  - hc counts 0..H_TOTAL-1 and wraps to 0.
  - vc increments when hc wraps, and wraps to 0 after V_TOTAL-1.
- Sync and enable:
  - Internal hs is active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs uses the same rule on vc.
  - de_int = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- Output pipeline: one register stage. hcount, vcount, de, hsync, vsync, rgb_* and frame_start all appear exactly 1 cycle after the counter value that produced them, and are mutually aligned.
- Reset values:
  - hc, vc = 0.
  - de = 0, rgb_* = 0, frame_start = 0.
  - hsync and vsync at the inactive level (~SYNC_POL).
  - hcount, vcount = 0; mode_active = 0.
  - box_x = box_y = 0; dx = dy = +1.
- Reset mid-frame: the counters restart at (0,0) on the next cycle. The first frame_start fires 1 cycle after reset deasserts.
- Mode latch: mode_in is sampled only when hc == 0 and vc == 0. mode_active therefore changes only at frame boundaries, so there are never mixed frames.
- Mode 0: rgb = solid_rgb while de = 1.
- Mode 1: eight vertical bars, BAR_W = H_ACTIVE/8.
  - Colour order: white, yellow, cyan, green, magenta, red, blue, black. A component is either all-ones or zero.
  - The bar index is derived from a per-line sub-counter with no divider: it resets at hc == 0 and advances each BAR_W pixels.
  - The index saturates at 7, so the last bar absorbs any remainder.
- Mode 2: white when hc[CHECK_LOG2] XOR vc[CHECK_LOG2] is 1, otherwise black.
- Mode 3: white when box_x <= hc < box_x+BOX_SIZE and box_y <= vc < box_y+BOX_SIZE, otherwise black.
  - box_x/box_y update once per frame, on the cycle where hc == 0 and vc == 0 (before pixel (0,0) is rendered).
  - X update: if dx = +1 and box_x == H_ACTIVE-BOX_SIZE, then dx := -1 and box_x := box_x-1. If dx = -1 and box_x == 0, then dx := +1 and box_x := 1. Otherwise box_x moves by dx. Y uses the same rule with V_ACTIVE.
  - The box updates in every frame regardless of mode, so its position stays continuous when the mode is switched.
- Blanking: outside the active area rgb_* = 0 in every mode.
- Width rules:
  - Counters are 10 bits; H_TOTAL and V_TOTAL must be at most 1024. An elaboration-time check fails otherwise.
  - Colour constants are replicated to COLOR_W bits.

Decomposition:
- Package vga_pkg holds:
  - the mode encoding constants (MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_BOX);
  - the 8-entry colour-bar table as 3-bit {r,g,b} on/off flags;
  - default 640x480@60 timing constants;
  - a function computing H_TOTAL/V_TOTAL.
- Sub-module vga_timing_gen owns hc/vc, the sync/de decode and the frame-start strobe.
- vga_pattern_gen contains the mode latch, pattern logic, box motion and output register stage.

Test Plan:
1. Reset held 5 cycles, then released with default parameters -> hsync low pulse of exactly 96 cycles starting 656 cycles after line start. Line period 800. vsync low for exactly 2 lines (1600 cycles) starting at line 490. frame_start period 420000 cycles.
2. mode_in = 0, solid_rgb = 9'b101_010_111 -> every de = 1 pixel has r = 5, g = 2, b = 7. Every de = 0 pixel has rgb = 0.
3. mode_in = 1 -> pixel x = 0..79 white (7,7,7), x = 80 yellow (7,7,0), x = 560..639 black. Bar transitions occur exactly at multiples of 80.
4. mode_in changed from 2 to 0 at mid-frame (line 200) -> mode_active stays 2 until the next frame_start; the checkerboard at (32,0) is white and at (0,0) black until then.
5. mode_in = 3 for 610 frames -> box_x reaches 608 at frame 608, then decreases to 607. Box pixels at (608..639, y) are white in that frame.
6. Reset asserted at line 300, pixel 400 for 1 cycle -> the next output reports hcount = 0, vcount = 0 with frame_start = 1, and hsync/vsync stay inactive until the normal sync windows.
